// File: rtl/aes_pkg.sv
// Shared types, sizes and GF(2^8) helpers for the AES-128 inverse cipher path.
package aes_pkg;

   localparam int unsigned NR      = 10;
   localparam int unsigned BLOCK_W = 128;
   localparam int unsigned RND_W   = 4;

   typedef logic [0:BLOCK_W-1] aes_block_t;

   typedef enum logic [1:0] {
      IDLE,
      ROUND,
      FINAL,
      DONE
   } ctrl_state_t;

   // Multiply by x modulo the AES polynomial x^8+x^4+x^3+x+1.
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   // General GF(2^8) product, shift-and-add.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] t;
      p = 8'h00;
      t = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ t;
         t = xtime(t);
      end
      return p;
   endfunction

   // Multiplicative inverse as a^254 = a^2 * a^4 * ... * a^128; maps 0 to 0.
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] p;
      logic [7:0] r;
      p = a;
      r = 8'h01;
      for (int i = 1; i < 8; i++) begin
         p = gf_mul(p, p);
         r = gf_mul(r, p);
      end
      return r;
   endfunction

   // Inverse S-box: undo the affine map, then invert in GF(2^8).
   function automatic logic [7:0] inv_sbox(input logic [7:0] b);
      logic [7:0] s;
      s = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
      return gf_inv(s);
   endfunction

   // InvMixColumns on one column; first byte of the column sits in [31:24].
   function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
      logic [7:0] a [4];
      logic [7:0] m9 [4];
      logic [7:0] mb [4];
      logic [7:0] md [4];
      logic [7:0] me [4];
      logic [7:0] x2, x4, x8;
      for (int i = 0; i < 4; i++) begin
         a[i]  = col[31-8*i -: 8];
         x2    = xtime(a[i]);
         x4    = xtime(x2);
         x8    = xtime(x4);
         m9[i] = x8 ^ a[i];
         mb[i] = x8 ^ x2 ^ a[i];
         md[i] = x8 ^ x4 ^ a[i];
         me[i] = x8 ^ x4 ^ x2;
      end
      return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
              m9[0] ^ me[1] ^ mb[2] ^ md[3],
              md[0] ^ m9[1] ^ me[2] ^ mb[3],
              mb[0] ^ md[1] ^ m9[2] ^ me[3]};
   endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns unless last.
module aes_inv_round
   import aes_pkg::*;
(
   input  aes_block_t st,
   input  aes_block_t rk,
   input  logic       last,
   output aes_block_t result
);

   aes_block_t sr_c;
   aes_block_t ark_c;

   aes_inv_shift_rows u_inv_shift_rows (
      .st     (st),
      .result (sr_c)
   );

   // Byte substitution and key add, then optional column mixing.
   always_comb begin
      ark_c  = '0;
      result = '0;
      for (int i = 0; i < 16; i++) begin
         ark_c[8*i +: 8] = inv_sbox(sr_c[8*i +: 8]) ^ rk[8*i +: 8];
      end
      result = ark_c;
      if (!last) begin
         for (int c = 0; c < 4; c++) begin
            result[32*c +: 32] = inv_mix_col(ark_c[32*c +: 32]);
         end
      end
   end

endmodule

// File: rtl/aes_inv_shift_rows.sv
// InvShiftRows: row r of the column-major state rotates right by r columns.
module aes_inv_shift_rows
   import aes_pkg::*;
(
   input  aes_block_t st,
   output aes_block_t result
);

   // Byte (r,c) of the result takes byte (r, c-r mod 4) of the input.
   for (genvar r = 0; r < 4; r++) begin : g_row
      for (genvar c = 0; c < 4; c++) begin : g_col
         assign result[8*(r+4*c) +: 8] = st[8*(r+4*((c+4-r)%4)) +: 8];
      end
   end

endmodule

// File: rtl/aes_inv_cipher_ctrl.sv
// Iterative AES-128 decrypt controller: one inverse round per clock, keys fetched by index.
module aes_inv_cipher_ctrl
   import aes_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  aes_block_t       in_data,
   output logic [RND_W-1:0] rk_addr,
   input  aes_block_t       rk_data,
   output logic             out_valid,
   input  logic             out_ready,
   output aes_block_t       out_data,
   output logic             busy
);

   ctrl_state_t      state;
   aes_block_t       st;
   logic [RND_W-1:0] rnd;
   logic             last_c;
   aes_block_t       round_c;

   assign last_c   = (state == FINAL);
   assign out_data = st;

   aes_inv_round u_inv_round (
      .st     (st),
      .rk     (rk_data),
      .last   (last_c),
      .result (round_c)
   );

   // FSM, round counter, state register and registered handshake outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         st        <= '0;
         rnd       <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         rk_addr   <= RND_W'(NR);
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  st       <= in_data ^ rk_data;
                  rnd      <= RND_W'(NR - 1);
                  rk_addr  <= RND_W'(NR - 1);
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  state    <= ROUND;
               end
            end
            ROUND: begin
               st <= round_c;
               if (rnd == RND_W'(1)) begin
                  rnd     <= '0;
                  rk_addr <= '0;
                  state   <= FINAL;
               end else begin
                  rnd     <= rnd - RND_W'(1);
                  rk_addr <= rnd - RND_W'(1);
               end
            end
            FINAL: begin
               st        <= round_c;
               rk_addr   <= '0;
               out_valid <= 1'b1;
               state     <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
                  rk_addr   <= RND_W'(NR);
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_inv_cipher_ctrl.sv
// Bench for aes_inv_cipher_ctrl: forward-cipher reference model, known-answer and random blocks.
module tb_aes_inv_cipher_ctrl;
   import aes_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   aes_block_t in_data;
   logic [3:0] rk_addr;
   aes_block_t rk_data;
   logic       out_valid;
   logic       out_ready;
   aes_block_t out_data;
   logic       busy;

   aes_block_t rk_rom [0:15];
   logic [7:0] sbox [0:255];

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   int acc_q [$];
   aes_block_t out_q [$];

   localparam logic [0:127] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [0:127] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [0:127] C1_PT  = 128'h00112233445566778899aabbccddeeff;

   always #5 clk = ~clk;

   assign rk_data = rk_rom[rk_addr];

   aes_inv_cipher_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .rk_addr   (rk_addr),
      .rk_data   (rk_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy)
   );

   // Handshake monitor: cycle stamps of accepts, payloads of completed outputs.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!rst && in_valid && in_ready) acc_q.push_back(cyc);
      if (!rst && out_valid && out_ready) out_q.push_back(out_data);
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model (forward AES-128) ----------------
   function automatic logic [7:0] m_xt(input logic [7:0] a);
      return 8'((a << 1) ^ (a[7] ? 9'h11b : 9'h000));
   endfunction

   function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] t = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ t;
         t = m_xt(t);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
      return 8'((a << n) | (a >> (8 - n)));
   endfunction

   task automatic build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (m_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   task automatic load_key(input logic [0:127] key);
      logic [31:0] w [0:43];
      logic [31:0] t;
      logic [7:0]  rc;
      for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
      rc = 8'h01;
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t  = {t[23:0], t[31:24]};
            t  = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
            rc = m_xt(rc);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 16; r++) rk_rom[r] = '0;
      for (int r = 0; r <= 10; r++) rk_rom[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   function automatic aes_block_t encrypt(input aes_block_t pt);
      logic [7:0] s [0:15];
      logic [7:0] t [0:15];
      logic [7:0] a0, a1, a2, a3;
      aes_block_t res;
      for (int i = 0; i < 16; i++) s[i] = pt[8*i +: 8] ^ rk_rom[0][8*i +: 8];
      for (int r = 1; r <= 10; r++) begin
         for (int i = 0; i < 16; i++) t[i] = sbox[s[i]];
         for (int rr = 0; rr < 4; rr++)
            for (int c = 0; c < 4; c++) s[rr+4*c] = t[rr+4*((c+rr)%4)];
         if (r < 10) begin
            for (int c = 0; c < 4; c++) begin
               a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
               s[4*c]   = m_xt(a0) ^ m_xt(a1) ^ a1 ^ a2 ^ a3;
               s[4*c+1] = a0 ^ m_xt(a1) ^ m_xt(a2) ^ a2 ^ a3;
               s[4*c+2] = a0 ^ a1 ^ m_xt(a2) ^ m_xt(a3) ^ a3;
               s[4*c+3] = m_xt(a0) ^ a0 ^ a1 ^ a2 ^ m_xt(a3);
            end
         end
         for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk_rom[r][8*i +: 8];
      end
      for (int i = 0; i < 16; i++) res[8*i +: 8] = s[i];
      return res;
   endfunction

   function automatic aes_block_t rand_block();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Accept one block and follow it to DONE, checking key index trace and latency.
   task automatic run_to_done(input aes_block_t ct, input aes_block_t pt, input string name);
      int n = 0;
      logic [3:0] exp_rk;
      while (!in_ready && n < 30) begin step(); n++; end
      tests++;
      if (!in_ready) begin
         fails++;
         $display("FAIL %s_ready: in_ready=%0b required 1", name, in_ready);
      end
      in_data  = ct;
      in_valid = 1'b1;
      tests++;
      if (rk_addr !== 4'd10) begin
         fails++;
         $display("FAIL %s_rk_accept: rk_addr=%0d required 10", name, rk_addr);
      end
      step();
      in_valid = 1'b0;
      for (int k = 0; k < 10; k++) begin
         exp_rk = (k <= 8) ? 4'(9 - k) : 4'd0;
         tests++;
         if (rk_addr !== exp_rk || out_valid !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL %s_trace k=%0d: rk_addr=%0d out_valid=%0b busy=%0b required %0d 0 1",
                     name, k, rk_addr, out_valid, busy, exp_rk);
         end
         step();
      end
      tests++;
      if (out_valid !== 1'b1 || out_data !== pt || rk_addr !== 4'd0 || in_ready !== 1'b0) begin
         fails++;
         $display("FAIL %s_result: out_valid=%0b out_data=%h rk_addr=%0d in_ready=%0b required 1 %h 0 0",
                  name, out_valid, out_data, rk_addr, in_ready, pt);
      end
   endtask

   task automatic finish_out(input string name);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || rk_addr !== 4'd10) begin
         fails++;
         $display("FAIL %s_handshake: out_valid=%0b in_ready=%0b busy=%0b rk_addr=%0d required 0 1 0 10",
                  name, out_valid, in_ready, busy, rk_addr);
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
      step(); step(); step();
      rst = 1'b0;
      tests++;
      if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %0b required 1", in_ready); end
      tests++;
      if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %0b required 0", out_valid); end
      tests++;
      if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %0b required 0", busy); end
      tests++;
      if (out_data !== '0) begin fails++; $display("FAIL reset_out_data: got %h required 0", out_data); end
      tests++;
      if (rk_addr !== 4'd10) begin fails++; $display("FAIL reset_rk_addr: got %0d required 10", rk_addr); end
   endtask

   task automatic test_kat();
      load_key(C1_KEY);
      run_to_done(C1_CT, C1_PT, "kat");
      finish_out("kat");
   endtask

   task automatic test_random();
      aes_block_t pt, ct;
      for (int i = 0; i < 4; i++) begin
         load_key(rand_block());
         pt = rand_block();
         ct = encrypt(pt);
         run_to_done(ct, pt, "random");
         finish_out("random");
      end
   endtask

   task automatic test_backpressure();
      aes_block_t pt, ct;
      load_key(rand_block());
      pt = rand_block();
      ct = encrypt(pt);
      run_to_done(ct, pt, "bp");
      for (int k = 0; k < 5; k++) begin
         in_valid = k[0];
         in_data  = rand_block();
         step();
         tests++;
         if (out_valid !== 1'b1 || out_data !== pt || in_ready !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL bp_hold k=%0d: out_valid=%0b out_data=%h in_ready=%0b busy=%0b required 1 %h 0 1",
                     k, out_valid, out_data, in_ready, busy, pt);
         end
      end
      in_valid = 1'b0;
      finish_out("bp");
   endtask

   task automatic test_back_to_back();
      int n = 0;
      load_key(C1_KEY);
      acc_q.delete();
      out_q.delete();
      in_data   = C1_CT;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      while (out_q.size() < 3 && n < 100) begin step(); n++; end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      tests++;
      if (out_q.size() != 3 || acc_q.size() != 3) begin
         fails++;
         $display("FAIL b2b_count: outputs=%0d accepts=%0d required 3 3", out_q.size(), acc_q.size());
      end else begin
         tests++;
         if (acc_q[1] - acc_q[0] != 12 || acc_q[2] - acc_q[0] != 24) begin
            fails++;
            $display("FAIL b2b_spacing: offsets=%0d,%0d required 12,24",
                     acc_q[1] - acc_q[0], acc_q[2] - acc_q[0]);
         end
         for (int i = 0; i < 3; i++) begin
            tests++;
            if (out_q[i] !== C1_PT) begin
               fails++;
               $display("FAIL b2b_data%0d: got %h required %h", i, out_q[i], C1_PT);
            end
         end
      end
      step();
   endtask

   task automatic test_reset_mid();
      aes_block_t pt, ct;
      load_key(rand_block());
      pt = rand_block();
      ct = encrypt(pt);
      out_q.delete();
      in_data  = ct;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      for (int k = 0; k < 5; k++) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      tests++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_data !== '0 || rk_addr !== 4'd10) begin
         fails++;
         $display("FAIL midreset_state: in_ready=%0b out_valid=%0b busy=%0b out_data=%h rk_addr=%0d required 1 0 0 0 10",
                  in_ready, out_valid, busy, out_data, rk_addr);
      end
      step(); step();
      tests++;
      if (out_valid !== 1'b0 || out_q.size() != 0) begin
         fails++;
         $display("FAIL midreset_no_output: out_valid=%0b outputs=%0d required 0 0", out_valid, out_q.size());
      end
      run_to_done(ct, pt, "midreset");
      finish_out("midreset");
   endtask

   task automatic test_reset_collisions();
      in_data  = rand_block();
      in_valid = 1'b1;
      rst      = 1'b1;
      step();
      rst = 1'b0;
      in_valid = 1'b0;
      tests++;
      if (busy !== 1'b0 || in_ready !== 1'b1 || rk_addr !== 4'd10) begin
         fails++;
         $display("FAIL rst_vs_in_valid: busy=%0b in_ready=%0b rk_addr=%0d required 0 1 10", busy, in_ready, rk_addr);
      end
      step();
      tests++;
      if (busy !== 1'b0) begin fails++; $display("FAIL rst_vs_in_valid_after: busy=%0b required 0", busy); end
      load_key(C1_KEY);
      run_to_done(C1_CT, C1_PT, "rst_done");
      rst       = 1'b1;
      out_ready = 1'b1;
      step();
      rst       = 1'b0;
      out_ready = 1'b0;
      tests++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== '0) begin
         fails++;
         $display("FAIL rst_vs_out_ready: out_valid=%0b busy=%0b out_data=%h required 0 0 0", out_valid, busy, out_data);
      end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
      for (int r = 0; r < 16; r++) rk_rom[r] = '0;
      build_sbox();
      test_reset();
      test_kat();
      test_random();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      test_reset_collisions();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
